// File: rtl/led_panel_4k_drv.sv
// HUB75 driver for a 64x64 RGB444 panel: 4096x12 frame buffer, 32 row pairs, 4-plane BCM.
// Port summary: clk, rst (async, active low), init (scan enable), panel outputs
//   PX_CLK, LATCH, NOE, ROW[4:0], RGB0[2:0] (rows 0-31), RGB1[2:0] (rows 32-63).
// Optional macro PANEL_WRITE_EN adds the wr_en/wr_addr/wr_data frame-buffer write port.
// Frame-buffer read latency is 1 clk. There is no backpressure: the panel is free-running while init=1.
module led_panel_4k_drv #(
  parameter int    DELAY_BASE = 64,
  parameter string MEM_FILE   = "image.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
`ifdef PANEL_WRITE_EN
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [11:0] wr_data,
`endif
  output logic        PX_CLK,
  output logic        LATCH,
  output logic        NOE,
  output logic [4:0]  ROW,
  output logic [2:0]  RGB0,
  output logic [2:0]  RGB1
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SHIFT   = 3'd1;
  localparam logic [2:0] S_LATCH   = 3'd2;
  localparam logic [2:0] S_DISPLAY = 3'd3;
  localparam logic [2:0] S_NEXT    = 3'd4;

  // Counter wide enough for the longest plane (DELAY_BASE << 3).
  localparam int CW = $clog2((DELAY_BASE << 3) + 1);

  logic [2:0]    state;
  logic [4:0]    row;
  logic [5:0]    col;
  logic          phase;
  logic [1:0]    plane;
  logic [CW-1:0] cnt;
  logic [CW-1:0] dly_last;

  logic [11:0]   mem [0:4095];
  logic [11:0]   rd0_dat;
  logic [11:0]   rd1_dat;
  logic [5:0]    rd_col;
  logic [4:0]    rd_row;

`ifdef PANEL_WRITE_EN
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
`endif

  // Addresses run one cycle ahead of the column being shifted: in phase 1 we
  // fetch column col+1, and in NEXT we fetch the row that the next SHIFT uses.
  // col wraps to 0 after column 63, so LATCH/DISPLAY/NEXT already point at column 0.
  always_comb begin
    rd_col = col;
    rd_row = row;
    if (state == S_SHIFT && phase) rd_col = col + 6'd1;
    if (state == S_NEXT && plane == 2'd3) rd_row = row + 5'd1;
  end

  // Two synchronous read ports; a same-cycle write returns the old word.
  always_ff @(posedge clk) begin
    rd0_dat <= mem[{1'b0, rd_row, rd_col}];
    rd1_dat <= mem[{1'b1, rd_row, rd_col}];
  end

  assign dly_last = CW'((DELAY_BASE << plane) - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      row   <= 5'd0;
      col   <= 6'd0;
      phase <= 1'b0;
      plane <= 2'd0;
      cnt   <= '0;
      ROW   <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (init) state <= S_SHIFT;
        end
        S_SHIFT: begin
          phase <= ~phase;
          if (phase) begin
            col <= col + 6'd1;
            if (col == 6'd63) begin
              state <= S_LATCH;
              ROW   <= row;
            end
          end
        end
        S_LATCH: begin
          state <= S_DISPLAY;
          cnt   <= '0;
        end
        S_DISPLAY: begin
          if (cnt == dly_last) state <= S_NEXT;
          else                 cnt   <= cnt + 1'b1;
        end
        S_NEXT: begin
          if (plane == 2'd3) begin
            plane <= 2'd0;
            row   <= row + 5'd1;
          end else begin
            plane <= plane + 2'd1;
          end
          // init is only sampled here, so a drop always completes the plane.
          state <= init ? S_SHIFT : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // {R,G,B} bit of the current plane: bit indices 8+p, 4+p, p.
  function automatic logic [2:0] pick(input logic [11:0] d, input logic [1:0] p);
    return {d[{2'b10, p}], d[{2'b01, p}], d[{2'b00, p}]};
  endfunction

  // Data is held across both phases so it is stable at the PX_CLK rising edge.
  assign PX_CLK = (state == S_SHIFT) && phase;
  assign LATCH  = (state == S_LATCH);
  assign NOE    = (state != S_DISPLAY);
  assign RGB0   = (state == S_SHIFT) ? pick(rd0_dat, plane) : 3'b000;
  assign RGB1   = (state == S_SHIFT) ? pick(rd1_dat, plane) : 3'b000;

endmodule

// File: tb/tb_led_panel_4k_drv.sv
// Directed bench for led_panel_4k_drv: reset, shift/latch/display timing,
// per-plane colour bits, frame wrap, init drop/resume, mid-scan reset, optional writes.
module tb_led_panel_4k_drv;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [11:0] wr_data;
  logic        PX_CLK;
  logic        LATCH;
  logic        NOE;
  logic [4:0]  ROW;
  logic [2:0]  RGB0;
  logic [2:0]  RGB1;

  int total = 0;
  int bad   = 0;

  led_panel_4k_drv #(.DELAY_BASE(64), .MEM_FILE("")) dut (
    .clk     (clk),
    .rst     (rst),
    .init    (init),
`ifdef PANEL_WRITE_EN
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`endif
    .PX_CLK  (PX_CLK),
    .LATCH   (LATCH),
    .NOE     (NOE),
    .ROW     (ROW),
    .RGB0    (RGB0),
    .RGB1    (RGB1)
  );

  always #5 clk = ~clk;

  task automatic load_mem(input logic [11:0] fill);
    for (int i = 0; i < 4096; i++) dut.mem[i] = fill;
  endtask

  task automatic do_reset();
    init = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Observes one bit plane from SHIFT through the NEXT cycle (sampled on negedges).
  // Reports measurements only; callers do the comparisons.
  task automatic measure_plane(input int col, output int edges, output int noe_low,
                               output int cycles, output logic [2:0] c0, output logic [2:0] c1,
                               output logic [2:0] and0, output logic [2:0] and1,
                               output logic [4:0] row_l, output int latches, output bit tmo);
    logic prev_px;
    bit   seen_low;
    bit   done;
    edges = 0; noe_low = 0; cycles = 0; c0 = '0; c1 = '0;
    and0 = 3'b111; and1 = 3'b111; row_l = '0; latches = 0; tmo = 0;
    prev_px = 1'b0; seen_low = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      cycles++;
      if (PX_CLK && !prev_px) begin
        if (edges == col) begin c0 = RGB0; c1 = RGB1; end
        and0 &= RGB0;
        and1 &= RGB1;
        edges++;
      end
      prev_px = PX_CLK;
      if (LATCH) begin latches++; row_l = ROW; end
      if (!NOE) begin noe_low++; seen_low = 1; end
      else if (seen_low) done = 1;
      if (cycles > 5000) begin tmo = 1; done = 1; end
    end
  endtask

  task automatic test_reset();
    int px_hi;
    load_mem(12'hFFF);
    init = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (PX_CLK !== 1'b0) begin bad++; $display("FAIL reset_pxclk got %b want 0", PX_CLK); end
    total++; if (LATCH !== 1'b0)  begin bad++; $display("FAIL reset_latch got %b want 0", LATCH); end
    total++; if (NOE !== 1'b1)    begin bad++; $display("FAIL reset_noe got %b want 1", NOE); end
    total++; if (ROW !== 5'd0)    begin bad++; $display("FAIL reset_row got %0d want 0", ROW); end
    total++; if (RGB0 !== 3'b000 || RGB1 !== 3'b000)
      begin bad++; $display("FAIL reset_rgb got %b/%b want 000/000", RGB0, RGB1); end
    @(negedge clk);
    rst = 1'b1;
    px_hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (PX_CLK !== 1'b0 || NOE !== 1'b1 || LATCH !== 1'b0) px_hi++;
    end
    total++; if (px_hi !== 0) begin bad++; $display("FAIL idle_quiet got %0d active samples want 0", px_hi); end
  endtask

  task automatic test_all_white();
    int e, nl, cy, lt; logic [2:0] c0, c1, a0, a1; logic [4:0] rl; bit tmo;
    load_mem(12'hFFF);
    do_reset();
    init = 1'b1;
    measure_plane(0, e, nl, cy, c0, c1, a0, a1, rl, lt, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL white_timeout got %0d want 0", tmo); end
    total++; if (e !== 64)  begin bad++; $display("FAIL white_edges got %0d want 64", e); end
    total++; if (lt !== 1)  begin bad++; $display("FAIL white_latch got %0d want 1", lt); end
    total++; if (a0 !== 3'b111 || a1 !== 3'b111)
      begin bad++; $display("FAIL white_rgb got %b/%b want 111/111", a0, a1); end
    total++; if (nl !== 64) begin bad++; $display("FAIL white_noe got %0d want 64", nl); end
    total++; if (rl !== 5'd0) begin bad++; $display("FAIL white_row got %0d want 0", rl); end
    total++; if (cy !== 130 + 64) begin bad++; $display("FAIL white_cycles got %0d want 194", cy); end
  endtask

  task automatic test_planes();
    int e, nl, cy, lt; logic [2:0] c0, c1, a0, a1; logic [4:0] rl; bit tmo;
    logic [2:0] exp0;
    load_mem(12'h000);
    dut.mem[0]    = 12'h800;
    dut.mem[2048] = 12'h00F;
    do_reset();
    init = 1'b1;
    for (int b = 0; b < 4; b++) begin
      measure_plane(0, e, nl, cy, c0, c1, a0, a1, rl, lt, tmo);
      exp0 = (b == 3) ? 3'b100 : 3'b000;
      total++; if (tmo !== 1'b0) begin bad++; $display("FAIL plane%0d_timeout got 1 want 0", b); end
      total++; if (c0 !== exp0) begin bad++; $display("FAIL plane%0d_rgb0 got %b want %b", b, c0, exp0); end
      total++; if (c1 !== 3'b001) begin bad++; $display("FAIL plane%0d_rgb1 got %b want 001", b, c1); end
      total++; if (nl !== (64 << b)) begin bad++; $display("FAIL plane%0d_noe got %0d want %0d", b, nl, 64 << b); end
      total++; if (rl !== 5'd0) begin bad++; $display("FAIL plane%0d_row got %0d want 0", b, rl); end
    end
  endtask

  task automatic test_frame();
    int e, nl, cy, lt, sum_cy, sum_lt; logic [2:0] c0, c1, a0, a1; logic [4:0] rl; bit tmo;
    load_mem(12'h000);
    do_reset();
    init = 1'b1;
    sum_cy = 0; sum_lt = 0;
    for (int p = 0; p < 128; p++) begin
      measure_plane(0, e, nl, cy, c0, c1, a0, a1, rl, lt, tmo);
      sum_cy += cy; sum_lt += lt;
      total++; if (rl !== 5'(p / 4) || tmo) begin bad++; $display("FAIL frame_row p=%0d got %0d want %0d", p, rl, p / 4); end
    end
    total++; if (sum_cy !== 32 * 1480) begin bad++; $display("FAIL frame_cycles got %0d want %0d", sum_cy, 32 * 1480); end
    total++; if (sum_lt !== 128) begin bad++; $display("FAIL frame_latches got %0d want 128", sum_lt); end
    measure_plane(0, e, nl, cy, c0, c1, a0, a1, rl, lt, tmo);
    total++; if (rl !== 5'd0 || nl !== 64) begin bad++; $display("FAIL frame_wrap got row %0d noe %0d want 0/64", rl, nl); end
  endtask

  task automatic test_init_drop();
    int e, nl, cy, lt, act; logic [2:0] c0, c1, a0, a1; logic [4:0] rl; bit tmo;
    load_mem(12'h000);
    do_reset();
    init = 1'b1;
    measure_plane(0, e, nl, cy, c0, c1, a0, a1, rl, lt, tmo);
    @(negedge clk);
    init = 1'b0;
    measure_plane(0, e, nl, cy, c0, c1, a0, a1, rl, lt, tmo);
    total++; if (nl !== 128 || e !== 64) begin bad++; $display("FAIL drop_finish got noe %0d edges %0d want 128/64", nl, e); end
    act = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (PX_CLK !== 1'b0 || NOE !== 1'b1 || LATCH !== 1'b0) act++;
    end
    total++; if (act !== 0) begin bad++; $display("FAIL drop_idle got %0d active samples want 0", act); end
    init = 1'b1;
    measure_plane(0, e, nl, cy, c0, c1, a0, a1, rl, lt, tmo);
    total++; if (nl !== 256) begin bad++; $display("FAIL drop_resume_plane got noe %0d want 256", nl); end
    total++; if (rl !== 5'd0) begin bad++; $display("FAIL drop_resume_row got %0d want 0", rl); end
  endtask

  task automatic test_reset_mid();
    int e, nl, cy, lt, n; logic [2:0] c0, c1, a0, a1; logic [4:0] rl; bit tmo;
    load_mem(12'hFFF);
    do_reset();
    init = 1'b1;
    for (int p = 0; p < 5; p++) measure_plane(0, e, nl, cy, c0, c1, a0, a1, rl, lt, tmo);
    total++; if (rl !== 5'd1) begin bad++; $display("FAIL mid_row_before got %0d want 1", rl); end
    n = 0;
    do begin @(negedge clk); n++; end while (PX_CLK !== 1'b1 && n < 20);
    total++; if (RGB0 !== 3'b111) begin bad++; $display("FAIL mid_shift_rgb got %b want 111", RGB0); end
    #1 rst = 1'b0;
    #1;
    total++; if (PX_CLK !== 1'b0 || NOE !== 1'b1 || LATCH !== 1'b0)
      begin bad++; $display("FAIL mid_reset_ctl got px %b noe %b latch %b want 0/1/0", PX_CLK, NOE, LATCH); end
    total++; if (ROW !== 5'd0 || RGB0 !== 3'b000 || RGB1 !== 3'b000)
      begin bad++; $display("FAIL mid_reset_data got row %0d rgb %b/%b want 0/000/000", ROW, RGB0, RGB1); end
    @(negedge clk);
    rst = 1'b1;
    init = 1'b0;
  endtask

`ifdef PANEL_WRITE_EN
  task automatic test_write();
    int e, nl, cy, lt; logic [2:0] c0, c1, a0, a1; logic [4:0] rl; bit tmo;
    logic [2:0] exp0;
    load_mem(12'h000);
    do_reset();
    wr_en = 1'b1; wr_addr = 12'd100; wr_data = 12'h004;
    @(negedge clk);
    wr_en = 1'b0;
    init = 1'b1;
    for (int p = 0; p < 4; p++) measure_plane(36, e, nl, cy, c0, c1, a0, a1, rl, lt, tmo);
    for (int b = 0; b < 4; b++) begin
      measure_plane(36, e, nl, cy, c0, c1, a0, a1, rl, lt, tmo);
      exp0 = (b == 2) ? 3'b001 : 3'b000;
      total++; if (rl !== 5'd1) begin bad++; $display("FAIL wr%0d_row got %0d want 1", b, rl); end
      total++; if (c0 !== exp0 || c1 !== 3'b000)
        begin bad++; $display("FAIL wr%0d_rgb got %b/%b want %b/000", b, c0, c1, exp0); end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    init = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    test_reset();
    test_all_white();
    test_planes();
    test_frame();
    test_init_drop();
    test_reset_mid();
`ifdef PANEL_WRITE_EN
    test_write();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
